// File: rtl/uart_echo_top.sv
// UART loopback: 8N1 receiver -> small byte FIFO -> 8N1 transmitter.
// Every correctly framed byte seen on RsRx is re-sent unchanged on RsTx.
module uart_echo_top #(
   parameter int unsigned CLKS_PER_BIT = 20,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic sys_clk,
   input  logic sw_0,
   input  logic RsRx,
   output logic RsTx
);

   localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
   localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

   // Input synchroniser, reset to the line idle level
   logic rx_meta_q, rx_s_q;

   always_ff @(posedge sys_clk) begin
      if (sw_0) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= RsRx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Receiver
   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            rx_ferr_q, rx_ferr_d;
   logic            rx_valid_q, rx_valid_d;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_ferr_d  = rx_ferr_q;
      rx_valid_d = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (!rx_s_q) begin
               rx_state_d = RxStart;
               rx_cnt_d   = '0;
            end
         end
         RxStart: begin
            if (rx_cnt_q == HalfLast) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s_q ? RxIdle : RxData;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxData: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 1'b1;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RxStop;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxStop: begin
            // After a low stop sample, keep waiting for the line to go idle
            if (rx_ferr_q || (rx_cnt_q == BitLast)) begin
               if (rx_s_q) begin
                  rx_valid_d = !rx_ferr_q;
                  rx_ferr_d  = 1'b0;
                  rx_cnt_d   = '0;
                  rx_state_d = RxIdle;
               end else begin
                  rx_ferr_d = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sw_0) begin
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_ferr_q  <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   // Byte FIFO; the extra pointer bit separates full from empty
   logic [7:0]     fifo_mem_q [FIFO_DEPTH];
   logic [AddrW:0] wr_ptr_q, rd_ptr_q;
   logic           fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic [7:0]     fifo_rdata;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                       (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
   // A pop in the same cycle frees the slot, so a full FIFO can still accept
   assign fifo_push  = rx_valid_q && (!fifo_full || fifo_pop);
   assign fifo_rdata = fifo_mem_q[rd_ptr_q[AddrW-1:0]];

   always_ff @(posedge sys_clk) begin
      if (sw_0) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (fifo_push) begin
         fifo_mem_q[wr_ptr_q[AddrW-1:0]] <= rx_shift_q;
      end
   end

   // Transmitter; the line level is registered one cycle behind the state
   tx_state_e       tx_state_q, tx_state_d;
   logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]      tx_bit_q, tx_bit_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            tx_q, tx_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_d       = 1'b1;
      fifo_pop   = 1'b0;
      unique case (tx_state_q)
         TxIdle: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               tx_shift_d = fifo_rdata;
               tx_cnt_d   = '0;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            tx_d = 1'b0;
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TxData;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxData: begin
            tx_d = tx_shift_q[0];
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 1'b1;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TxStop;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxStop: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d = '0;
               // Chain straight into the next frame with no idle cycle
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  tx_shift_d = fifo_rdata;
                  tx_state_d = TxStart;
               end else begin
                  tx_state_d = TxIdle;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sw_0) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   assign RsTx = tx_q;

endmodule

// File: tb/tb_uart_echo_top.sv
// Bench for uart_echo_top: drives 8N1 frames on RsRx, predicts echoed bytes and
// their exact start-bit cycle from a timing-level FIFO model, decodes RsTx.
module tb_uart_echo_top;

   localparam int CPB         = 20;
   localparam int DEPTH       = 4;
   localparam int FramePeriod = 10 * CPB;
   // Edge (relative to start-bit drive) at which the stop bit is sampled
   localparam int StopSample  = 3 + CPB / 2 + 9 * CPB;
   localparam int MinStop     = CPB / 2 + 2;

   logic sys_clk = 1'b0;
   logic sw_0    = 1'b1;
   logic RsRx    = 1'b1;
   logic RsTx;

   int cyc    = 0;
   int n_cmp  = 0;
   int n_bad  = 0;
   int n_drop = 0;

   typedef struct {
      logic [7:0] data;
      int         fall;
   } exp_t;

   exp_t exp_q[$];
   int   pend_q[$];
   int   last_pop  = -1000000;
   bit   mon_busy  = 1'b0;
   bit   mon_abort = 1'b0;

   uart_echo_top #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .sys_clk(sys_clk),
      .sw_0   (sw_0),
      .RsRx   (RsRx),
      .RsTx   (RsTx)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      RsRx = v;
      tick(n);
   endtask

   // Byte reaches the FIFO at edge w; it is dropped if DEPTH bytes are still
   // waiting (a pop at the same edge frees a slot). TX takes a byte one edge
   // after it lands, or when the previous frame ends, whichever is later.
   task automatic model_write(input logic [7:0] b, input int w);
      int p;
      while (pend_q.size() > 0 && pend_q[0] <= w) void'(pend_q.pop_front());
      if (pend_q.size() < DEPTH) begin
         p = (w + 1 > last_pop + FramePeriod) ? w + 1 : last_pop + FramePeriod;
         pend_q.push_back(p);
         last_pop = p;
         exp_q.push_back('{data: b, fall: p + 1});
      end else begin
         n_drop++;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input int stop_len, input bit stop_ok);
      if (stop_ok) model_write(b, cyc + StopSample + 1);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
      if (stop_ok) begin
         drive_bit(1'b1, stop_len);
      end else begin
         drive_bit(1'b0, CPB);
         drive_bit(1'b1, CPB);
      end
   endtask

   task automatic do_reset(input int n);
      sw_0 = 1'b1;
      exp_q.delete();
      pend_q.delete();
      last_pop = -1000000;
      if (mon_busy) mon_abort = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         check("rstx_high_in_reset", RsTx, 1'b1);
      end
      sw_0 = 1'b0;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < 40 * FramePeriod) begin
         tick(1);
         n++;
      end
      check(name, (exp_q.size() != 0 || mon_busy), 1'b0);
      tick(4 * CPB);
   endtask

   // Monitor: decode each RsTx frame and compare with the scoreboard head
   initial begin
      logic       prev;
      logic [7:0] d;
      logic       st, sp;
      exp_t       e;
      bit         have;
      int         f;
      prev = 1'b1;
      forever begin
         @(negedge sys_clk);
         if (prev === 1'b1 && RsTx === 1'b0) begin
            mon_busy = 1'b1;
            f        = cyc;
            have     = (exp_q.size() != 0);
            if (have) e = exp_q.pop_front();
            repeat (CPB / 2) @(negedge sys_clk);
            st = RsTx;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge sys_clk);
               d[i] = RsTx;
            end
            repeat (CPB) @(negedge sys_clk);
            sp = RsTx;
            if (mon_abort) begin
               mon_abort = 1'b0;
            end else if (!have) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_frame: got byte %02h at cycle %0d, required no frame", d, f);
            end else begin
               check("echo_byte", d, e.data);
               check("echo_start_cycle", f, e.fall);
               check("start_bit", st, 1'b0);
               check("stop_bit", sp, 1'b1);
            end
            mon_busy = 1'b0;
         end
         prev = RsTx;
      end
   end

   initial begin
      logic [7:0] b;
      int         n;

      // 1: reset holds RsTx high, then a single byte with minimum latency
      do_reset(3);
      tick(5);
      send_frame(8'h01, CPB, 1'b1);
      drain("t1_drained");

      // 2: continuous stream at full line rate
      repeat (5) send_frame(8'h01, CPB, 1'b1);
      send_frame(8'hAB, CPB, 1'b1);
      send_frame(8'h10, CPB, 1'b1);
      drain("t2_drained");

      // 3: framing error dropped, following byte echoed
      send_frame(8'h5A, CPB, 1'b0);
      send_frame(8'h3C, CPB, 1'b1);
      drain("t3_drained");

      // 4: short start-bit glitch is ignored
      drive_bit(1'b0, 5);
      drive_bit(1'b1, 3 * CPB);
      drain("t4_drained");
      b = 8'($urandom);
      send_frame(b, CPB, 1'b1);
      drain("t4_after_glitch");

      // Random bytes, stop lengths, gaps and occasional framing errors
      repeat (24) begin
         b = 8'($urandom);
         if ($urandom_range(0, 5) == 0) send_frame(b, CPB, 1'b0);
         else send_frame(b, MinStop + int'($urandom_range(0, 3 * CPB)), 1'b1);
      end
      drain("rand_drained");

      // 5: burst with shortened stop bits, then a long one that overfills the FIFO
      for (int i = 0; i < 6; i++) send_frame(8'h11 + 8'(i), MinStop, 1'b1);
      drain("t5_drained");
      repeat (140) send_frame(8'($urandom), MinStop, 1'b1);
      drive_bit(1'b1, 2 * CPB);

      // 6: one-cycle reset in the middle of a TX frame with bytes still queued
      n = 0;
      while (!mon_busy && n < 2 * FramePeriod) begin
         tick(1);
         n++;
      end
      check("t6_tx_busy", mon_busy, 1'b1);
      tick(3 * CPB);
      do_reset(1);
      send_frame(8'hFF, CPB, 1'b1);
      drain("t6_drained");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
